// File: rtl/aes_inv_round.sv
// AES inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Two registered stages share one advance enable so downstream backpressure freezes the whole pipe.
module aes_inv_round #(
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] state_in,
    input  logic [KEY_W-1:0] round_key,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] state_out
);
    generate
        if (KEY_W != 128) begin : g_width_check
            $error("aes_inv_round supports only KEY_W = 128");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0; 254 = 0b11111110.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] base;
        acc  = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) acc = gf_mul(acc, base);
            base = gf_mul(base, base);
        end
        return acc;
    endfunction

    // Inverse affine map (rotations by 1, 3, 6 plus 0x05) followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic             adv;
    logic             s1_valid_reg;
    logic             last_s1_reg;
    logic             out_valid_reg;
    logic [KEY_W-1:0] s1_data_reg;
    logic [KEY_W-1:0] key_s1_reg;
    logic [KEY_W-1:0] state_out_reg;
    logic [KEY_W-1:0] sub_bytes;
    logic [KEY_W-1:0] added;
    logic [KEY_W-1:0] mixed;

    genvar gi;

    // Byte gi sits at row gi%4, column gi/4; its source column is rotated right by the row index.
    for (gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
        assign sub_bytes[127-8*gi -: 8] = inv_sbox(state_in[127-8*SRC -: 8]);
    end

    assign added = s1_data_reg ^ key_s1_reg;

    for (gi = 0; gi < 4; gi++) begin : g_col
        assign mixed[127-32*gi -: 32] = inv_mix_col(added[127-32*gi -: 32]);
    end

    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            last_s1_reg   <= 1'b0;
            s1_data_reg   <= '0;
            key_s1_reg    <= '0;
            out_valid_reg <= 1'b0;
            state_out_reg <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg <= sub_bytes;
                key_s1_reg  <= round_key;
                last_s1_reg <= last;
            end
            out_valid_reg <= s1_valid_reg;
            state_out_reg <= last_s1_reg ? added : mixed;
        end
    end

    assign out_valid = out_valid_reg;
    assign state_out = state_out_reg;
endmodule

// File: tb/tb_aes_inv_round.sv
// Randomized scoreboard bench for aes_inv_round against a table-driven reference of the inverse round.
`timescale 1ns/1ps
module tb_aes_inv_round;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic [127:0] round_key = '0;
    logic         last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;

    aes_inv_round #(.KEY_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] V1_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_OUT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_IN  = {16{8'h63}};
    localparam logic [127:0] V2_KEY = {4{32'h8e4da1bc}};
    localparam logic [127:0] V2_OUT = {4{32'hdb135345}};

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [127:0] exp_q[$];
    int           out_cycles[$];
    logic [7:0]   inv_sbox_tbl[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11b;
        end
        return p;
    endfunction

    // Forward S-box from brute-force inverse plus forward affine map, then inverted into a table.
    task automatic build_tables();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
            s = inv;
            for (int r = 1; r <= 4; r++) s = s ^ (((inv << r) | (inv >> (8 - r))) & 'hff);
            s = s ^ 'h63;
            inv_sbox_tbl[s] = x[7:0];
        end
    endtask

    function automatic int coef(input int r, input int j);
        case ((j - r + 4) % 4)
            0:       return 'h0e;
            1:       return 'h0b;
            2:       return 'h0d;
            default: return 'h09;
        endcase
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic lst);
        logic [7:0]   a [4][4];
        int           b [4][4];
        int           v;
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[r][c] = s[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = int'(inv_sbox_tbl[a[r][(c + 4 - r) % 4]] ^ k[127-8*(4*c+r) -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                v = 0;
                if (lst) v = b[r][c];
                else for (int j = 0; j < 4; j++) v = v ^ gmul(coef(r, j), b[j][c]);
                o[127-8*(4*c+r) -: 8] = v[7:0];
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks hold behaviour under stall.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_out = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_int("hold_valid", int'(out_valid), 1);
                check128("hold_data", state_out, prev_out);
            end
            if (out_valid && out_ready) begin
                out_cycles.push_back(cyc);
                $display("[%0d] out %h", cyc, state_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected none", state_out);
                end else begin
                    check128("result", state_out, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = state_out;
        end
    end

    // Caller enters just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                        input logic [127:0] req, output int stalls, output int acc_cyc);
        bit done;
        done    = 1'b0;
        stalls  = 0;
        acc_cyc = 0;
        state_in  = s;
        round_key = k;
        last      = l;
        in_valid  = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(req);
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int k;
        k = 0;
        while (out_cycles.size() < n && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_int(name, out_cycles.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int      st;
        int      acc;
        int      total_stalls;
        bit      sender_done;
        logic    lst;
        logic [127:0] s;
        logic [127:0] k;
        logic [127:0] held;
        bit      pat [5];

        build_tables();

        // Reset state
        #12;
        check_int("rst_out_valid", int'(out_valid), 0);
        check128("rst_state_out", state_out, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_int("in_ready_after_rst", int'(in_ready), 1);

        // Directed vectors with latency check
        out_cycles.delete();
        send(V1_IN, V1_KEY, 1'b1, V1_OUT, st, acc);
        wait_outputs(1, "vec1_count");
        if (out_cycles.size() > 0) check_int("vec1_latency", out_cycles[0] - acc, 2);
        out_cycles.delete();
        send(V2_IN, V2_KEY, 1'b0, V2_OUT, st, acc);
        wait_outputs(1, "vec2_count");
        if (out_cycles.size() > 0) check_int("vec2_latency", out_cycles[0] - acc, 2);
        idle(3);

        // Streaming: 8 back-to-back items
        out_cycles.delete();
        total_stalls = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(V1_IN, V1_KEY, 1'b1, V1_OUT, st, acc);
            else            send(V2_IN, V2_KEY, 1'b0, V2_OUT, st, acc);
            total_stalls += st;
        end
        check_int("stream_in_ready_stalls", total_stalls, 0);
        wait_outputs(8, "stream_count");
        for (int i = 1; i < out_cycles.size(); i++)
            check_int("stream_gap", out_cycles[i] - out_cycles[i-1], 1);
        idle(3);

        // Backpressure: hold out_ready low for 5 cycles with a result pending
        out_cycles.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    s   = rand128();
                    k   = rand128();
                    lst = 1'(i == 1);
                    send(s, k, lst, ref_round(s, k, lst), st, acc);
                end
            end
            begin
                for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
                @(negedge clk);
                held = state_out;
                repeat (5) begin
                    check_int("bp_out_valid", int'(out_valid), 1);
                    check128("bp_state_out", state_out, held);
                    check_int("bp_in_ready", int'(in_ready), 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_outputs(3, "bp_count");
        idle(4);
        check_int("bp_no_loss", exp_q.size(), 0);

        // Asynchronous reset with two items in flight
        out_cycles.delete();
        send(V1_IN, V1_KEY, 1'b1, V1_OUT, st, acc);
        send(V2_IN, V2_KEY, 1'b0, V2_OUT, st, acc);
        #3;
        rst = 1'b1;
        #1;
        check_int("midrst_out_valid", int'(out_valid), 0);
        check128("midrst_state_out", state_out, '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_cycles.delete();
        s = rand128();
        k = rand128();
        send(s, k, 1'b0, ref_round(s, k, 1'b0), st, acc);
        wait_outputs(1, "postrst_count");
        if (out_cycles.size() > 0) check_int("postrst_latency", out_cycles[0] - acc, 2);
        idle(4);
        check_int("postrst_only_fresh", out_cycles.size(), 1);

        // Bubble: in_valid 1,0,1 gives out_valid 1,0,1 two cycles later
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            s   = rand128();
            k   = rand128();
            lst = 1'($urandom_range(0, 1));
            state_in  = s;
            round_key = k;
            last      = lst;
            in_valid  = pat[i];
            @(negedge clk);
            if (pat[i]) begin
                check_int("bubble_in_ready", int'(in_ready), 1);
                exp_q.push_back(ref_round(s, k, lst));
            end
            if (i >= 2) check_int("bubble_out_valid", int'(out_valid), int'(pat[i-2]));
            @(posedge clk);
            #1;
        end
        idle(4);

        // Random traffic with random backpressure
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    s   = rand128();
                    k   = rand128();
                    lst = 1'($urandom_range(0, 1));
                    send(s, k, lst, ref_round(s, k, lst), st, acc);
                end
                sender_done = 1'b1;
            end
            begin
                while (!sender_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        check_int("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
